// File: rtl/sum_accumulator.sv
// sum_accumulator: block accumulator for the adder's sum stream.
// Emits total and truncated average every 2^LOG2_N samples.
module sum_accumulator #(
  parameter int SUM_W  = 9,
  parameter int LOG2_N = 3,
  parameter int ACC_W  = SUM_W + LOG2_N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [SUM_W-1:0] out_avg
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t            state, state_n;
  logic [ACC_W-1:0]  acc, acc_n;
  logic [LOG2_N-1:0] cnt, cnt_n;
  logic              valid_n;
  logic [ACC_W-1:0]  total_n;
  logic [SUM_W-1:0]  avg_n;
  logic [ACC_W-1:0]  sum;
  logic              accept;
  logic              last;

  // A slot opens when idle-collecting or when the held result leaves.
  assign in_ready = (state == ACCUM) || out_ready;
  // A sample arriving alongside clear is dropped.
  assign accept   = in_valid && in_ready && !clear;
  assign sum      = acc + ACC_W'(in_sum);
  assign last     = &cnt;

  // Next-state, accumulator and result update.
  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    valid_n = out_valid;
    total_n = out_total;
    avg_n   = out_avg;
    if (clear) begin
      state_n = ACCUM;
      acc_n   = '0;
      cnt_n   = '0;
      valid_n = 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (accept) begin
            if (last) begin
              total_n = sum;
              avg_n   = SUM_W'(sum >> LOG2_N);
              valid_n = 1'b1;
              acc_n   = '0;
              cnt_n   = '0;
              state_n = HOLD;
            end else begin
              acc_n = sum;
              cnt_n = cnt + LOG2_N'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            valid_n = 1'b0;
            state_n = ACCUM;
            if (accept) begin
              acc_n = ACC_W'(in_sum);
              cnt_n = LOG2_N'(1);
            end
          end
        end
        default: begin
          state_n = ACCUM;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_total <= '0;
      out_avg   <= '0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      out_valid <= valid_n;
      out_total <= total_n;
      out_avg   <= avg_n;
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: directed bench for sum_accumulator.
// Defaults: SUM_W=9, LOG2_N=3 (N=8), ACC_W=12.
module tb_sum_accumulator;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_sum;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_total;
  logic [8:0]  out_avg;

  int tests;
  int failed;

  sum_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_total (out_total),
    .out_avg   (out_avg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer one sample and wait (bounded) until it is accepted.
  task automatic push(input logic [8:0] v);
    int k;
    in_valid = 1'b1;
    in_sum   = v;
    k = 0;
    #0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) begin
      tests++;
      failed++;
      $display("FAIL push_timeout got in_ready=%b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_out(input string name, input logic v,
                           input logic [11:0] t, input logic [8:0] a);
    tests++;
    if (out_valid !== v || out_total !== t || out_avg !== a) begin
      failed++;
      $display("FAIL %s got v=%b t=%0d a=%0d want v=%b t=%0d a=%0d",
               name, out_valid, out_total, out_avg, v, t, a);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    tests++;
    if (out_valid !== 1'b0 || out_total !== 12'd0 ||
        out_avg !== 9'd0 || in_ready !== 1'b1) begin
      failed++;
      $display("FAIL reset got v=%b t=%0d a=%0d r=%b want 0 0 0 1",
               out_valid, out_total, out_avg, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_scale;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) push(9'd510);
    check_out("max_before_last", 1'b0, 12'd0, 9'd0);
    push(9'd510);
    check_out("max_block", 1'b1, 12'd4080, 9'd510);
    tick();
    check_out("max_consumed", 1'b0, 12'd4080, 9'd510);
  endtask

  task automatic test_truncate;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(9'(i));
    check_out("ramp_block", 1'b1, 12'd36, 9'd4);
    tick();
    for (int i = 0; i < 8; i++) push(9'd0);
    check_out("zero_block", 1'b1, 12'd0, 9'd0);
    tick();
  endtask

  task automatic test_hold;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(9'd10);
    check_out("hold_block", 1'b1, 12'd80, 9'd10);
    in_valid = 1'b1;
    in_sum   = 9'd77;
    for (int i = 0; i < 5; i++) begin
      #0;
      tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_total !== 12'd80) begin
        failed++;
        $display("FAIL hold_stall got r=%b v=%b t=%0d want 0 1 80",
                 in_ready, out_valid, out_total);
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
      failed++;
      $display("FAIL hold_release got r=%b v=%b want 1 1", in_ready, out_valid);
    end
    tick();
    check_out("hold_consumed", 1'b0, 12'd80, 9'd10);
    for (int i = 0; i < 8; i++) push(9'd2);
    check_out("hold_no_leak", 1'b1, 12'd16, 9'd2);
    tick();
  endtask

  task automatic test_back_to_back;
    int acc_n;
    int res;
    int at0;
    int at1;
    acc_n = 0;
    res = 0;
    at0 = -1;
    at1 = -1;
    out_ready = 1'b1;
    in_sum = 9'd100;
    for (int c = 0; c < 30; c++) begin
      in_valid = (acc_n < 16);
      #0;
      if (in_valid && in_ready) acc_n++;
      tick();
      if (out_valid) begin
        if (res == 0) at0 = acc_n;
        if (res == 1) at1 = acc_n;
        res++;
        tests++;
        if (out_total !== 12'd800 || out_avg !== 9'd100 || in_ready !== 1'b1) begin
          failed++;
          $display("FAIL b2b_result got t=%0d a=%0d r=%b want 800 100 1",
                   out_total, out_avg, in_ready);
        end
      end
    end
    in_valid = 1'b0;
    tests++;
    if (res != 2 || at0 != 8 || at1 != 16) begin
      failed++;
      $display("FAIL b2b_spacing got n=%0d at=%0d,%0d want 2 at 8,16",
               res, at0, at1);
    end
  endtask

  task automatic test_clear;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(9'd50);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_sum   = 9'd99;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) push(9'd10);
    check_out("clear_partial", 1'b1, 12'd80, 9'd10);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(9'd7);
    check_out("clear_hold_pre", 1'b1, 12'd56, 9'd7);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_out("clear_hold", 1'b0, 12'd56, 9'd7);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_out("clear_no_result", 1'b0, 12'd56, 9'd7);
  endtask

  task automatic test_async_reset;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(9'd20);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_reset", 1'b0, 12'd0, 9'd0);
    tests++;
    if (in_ready !== 1'b1) begin
      failed++;
      $display("FAIL async_ready got %b want 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) push(9'd1);
    check_out("after_reset", 1'b1, 12'd8, 9'd1);
    tick();
  endtask

  initial begin
    tests     = 0;
    failed    = 0;
    rst_n     = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = 9'd0;
    out_ready = 1'b0;
    #2;
    test_reset();
    test_full_scale();
    test_truncate();
    test_hold();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
